cpu_ad48_lsu: RTL
=================

# cpu_ad48_lsu

Parametrised load/store unit for the ad48 core. It sits between the execute stage and a private data-memory array and performs word loads and stores with base+displacement addressing and optional address-register update (post-increment or pre-increment). It adds a valid/ready request/response handshake, a configurable memory latency, and an out-of-range fault that the single-cycle data path does not provide.

## Interface
Parameters:
- DATA_W, 48, data and address-register width.
- DEPTH, 128, number of memory words; power of two, at least 2. The index width is log2(DEPTH).
- LAT, 1, memory access latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_mode  in  2  00 = offset, 01 = post-increment, 10 = pre-increment, 11 = offset.
- req_base  in  DATA_W  address-register value.
- req_disp  in  DATA_W  displacement, already sign-extended.
- req_wdata  in  DATA_W  store data.
- req_dreg  in  3  destination data-register tag; returned unchanged.
- req_areg  in  3  address-register tag; returned unchanged.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_store  out  1  echo of req_store.
- rsp_rdata  out  DATA_W  load data; 0 for stores and for faults.
- rsp_dreg, rsp_areg  out  3  echoed tags.
- rsp_awb_en  out  1  address-register writeback required.
- rsp_awb_data  out  DATA_W  new address-register value.
- rsp_fault  out  1  effective address was out of range.

## Operation
- The state machine has three states: IDLE, ACCESS and RESP. req_ready is 1 only in IDLE and when rst is low.
- **Acceptance:** a request is accepted on a rising edge where req_valid && req_ready. On that edge the unit:
  - latches every request field;
  - computes sum = req_base + req_disp, modulo 2^DATA_W;
  - computes eff = req_base in mode 01, otherwise eff = sum.
- **Fault:** fault = (eff >= DEPTH), compared over the full DATA_W width. This covers a negative wrap, e.g. 0 + (-1) gives 0xFFFF_FFFF_FFFF, which faults.
- **ACCESS:** a counter is loaded with LAT-1 at acceptance. Each edge in ACCESS decrements it. When the counter is 0 at an edge, the state moves to RESP. On that same edge:
  - a non-faulting store writes mem[eff] = wdata;
  - a non-faulting load captures mem[eff] into rsp_rdata.
- Faulting requests take the same path with the same latency, but make no memory access and return rsp_rdata = 0.
- **Address writeback:** rsp_awb_en = (mode is 01 or 10) && areg != 0 && !fault, and rsp_awb_data = sum. Register A0 is hard-wired zero, so it is never updated. When rsp_awb_en = 0, rsp_awb_data is 0.
- **RESP:** rsp_valid = 1 and all rsp_* outputs are held stable until a rising edge where rsp_ready = 1. That edge returns the state to IDLE and clears rsp_valid and every rsp_* output to 0.
- **Memory array:** named mem, DATA_W x DEPTH, with no reset. The bench preloads it hierarchically.
- **Ordering:** a store is committed before its response is visible, so a load issued afterwards always sees the stored value.

## Timing
- **Reset** (asynchronous, immediate): state = IDLE, req_ready = 0 while rst is high, and every rsp_* output = 0. req_ready rises combinationally from the IDLE state once rst is deasserted.
- **Reset mid-operation:** any in-flight request is discarded. A store that has not yet reached its commit edge never writes memory.
- **Latency:** call the accept edge E0. rsp_valid is 1 from edge E0+LAT onward. The earliest next accept is the edge after the rsp_ready handshake edge, so the minimum request period is LAT+2 cycles.
- **Backpressure:** while rsp_valid = 1 and rsp_ready = 0, outputs are frozen and req_ready = 0. req_valid may be held high without effect.
- Request inputs are ignored in every state except IDLE.

## Test plan
- **Load, offset and post-increment** (LAT=1; mem[0..8] preloaded with 100..900):
  - offset load, base=2, disp=0 → rsp_rdata=300, awb_en=0, rsp_valid at E0+1;
  - post-increment load, base=2, disp=2, areg=1 → rdata=300, awb_en=1, awb_data=4.
- **Pre-increment load:** base=4, disp=-1, areg=2 → eff=3, rdata=400, awb_data=3.
- **Store then load:** store wdata=12345 at base=4, disp=0 → mem[4]=12345, rsp_rdata=0. A following load of base=4 returns 12345.
- **A0 is never written:** post-increment store with areg=0, base=5, disp=3, wdata=67890 → mem[5]=67890 and awb_en=0.
- **Faults:**
  - base=127, disp=1 → fault=1, rdata=0, awb_en=0, memory unchanged;
  - base=0, disp=-1 → fault=1.
- **Latency, backpressure and reset** (LAT=3):
  - rsp_valid rises exactly 3 edges after accept;
  - with rsp_ready held low for 5 cycles, outputs stay stable and req_ready stays 0;
  - rst asserted one edge after a store is accepted → all outputs 0 and the target word keeps its old value.

Source files
------------

// File: rtl/cpu_ad48_lsu.sv
// Load/store unit for the ad48 core: base+displacement word access to a private
// memory array with optional address-register update, handshakes and range fault.
module cpu_ad48_lsu #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 128,
    parameter int LAT    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_store,
    input  logic [1:0]        i_req_mode,
    input  logic [DATA_W-1:0] i_req_base,
    input  logic [DATA_W-1:0] i_req_disp,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [2:0]        i_req_dreg,
    input  logic [2:0]        i_req_areg,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_store,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic [2:0]        o_rsp_dreg,
    output logic [2:0]        o_rsp_areg,
    output logic              o_rsp_awb_en,
    output logic [DATA_W-1:0] o_rsp_awb_data,
    output logic              o_rsp_fault
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [1:0]        CNT_INIT = 2'(LAT - 1);
    localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              r_store;
    logic [1:0]        r_mode;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_dreg;
    logic [2:0]        r_areg;
    logic              r_fault;
    logic [1:0]        r_cnt;

    logic              r_rsp_valid;
    logic              r_rsp_store;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [2:0]        r_rsp_dreg;
    logic [2:0]        r_rsp_areg;
    logic              r_rsp_awb_en;
    logic [DATA_W-1:0] r_rsp_awb_data;
    logic              r_rsp_fault;

    logic              w_accept;
    logic              w_commit;
    logic              w_release;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_eff;
    logic              w_fault;
    logic              w_awb_en;
    logic [DATA_W-1:0] w_rd_word;

    // A0 is hard-wired zero, so only updating modes on a nonzero register write back.
    function automatic logic awb_required(input logic [1:0] mode,
                                          input logic [2:0] areg,
                                          input logic       fault);
        awb_required = ((mode == 2'b01) || (mode == 2'b10)) && (areg != 3'd0) && !fault;
    endfunction

    assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
    assign w_accept    = i_req_valid && o_req_ready;

    // The range check spans the full width so that negative wraps fault too.
    assign w_sum     = i_req_base + i_req_disp;
    assign w_eff     = (i_req_mode == 2'b01) ? i_req_base : w_sum;
    assign w_fault   = (w_eff >= DEPTH_W);
    assign w_awb_en  = awb_required(r_mode, r_areg, r_fault);
    assign w_rd_word = mem[r_idx];

    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_store    = r_rsp_store;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_dreg     = r_rsp_dreg;
    assign o_rsp_areg     = r_rsp_areg;
    assign o_rsp_awb_en   = r_rsp_awb_en;
    assign o_rsp_awb_data = r_rsp_awb_data;
    assign o_rsp_fault    = r_rsp_fault;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-edge control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = ST_RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_release   = 1'b1;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture, latency counter and response registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_store        <= 1'b0;
            r_mode         <= 2'd0;
            r_idx          <= '0;
            r_sum          <= '0;
            r_wdata        <= '0;
            r_dreg         <= 3'd0;
            r_areg         <= 3'd0;
            r_fault        <= 1'b0;
            r_cnt          <= 2'd0;
            r_rsp_valid    <= 1'b0;
            r_rsp_store    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_dreg     <= 3'd0;
            r_rsp_areg     <= 3'd0;
            r_rsp_awb_en   <= 1'b0;
            r_rsp_awb_data <= '0;
            r_rsp_fault    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_store <= i_req_store;
                r_mode  <= i_req_mode;
                r_idx   <= w_eff[IDX_W-1:0];
                r_sum   <= w_sum;
                r_wdata <= i_req_wdata;
                r_dreg  <= i_req_dreg;
                r_areg  <= i_req_areg;
                r_fault <= w_fault;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == ST_ACCESS) && !w_commit) begin
                r_cnt <= r_cnt - 2'd1;
            end

            if (w_commit) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_store    <= r_store;
                r_rsp_rdata    <= (!r_store && !r_fault) ? w_rd_word : '0;
                r_rsp_dreg     <= r_dreg;
                r_rsp_areg     <= r_areg;
                r_rsp_awb_en   <= w_awb_en;
                r_rsp_awb_data <= w_awb_en ? r_sum : '0;
                r_rsp_fault    <= r_fault;
            end else if (w_release) begin
                r_rsp_valid    <= 1'b0;
                r_rsp_store    <= 1'b0;
                r_rsp_rdata    <= '0;
                r_rsp_dreg     <= 3'd0;
                r_rsp_areg     <= 3'd0;
                r_rsp_awb_en   <= 1'b0;
                r_rsp_awb_data <= '0;
                r_rsp_fault    <= 1'b0;
            end
        end
    end

    // Memory array has no reset; a reset forces IDLE so a pending store never commits.
    always_ff @(posedge i_clk) begin
        if (w_commit && r_store && !r_fault) begin
            mem[r_idx] <= r_wdata;
        end
    end

endmodule
